mac_tx_arb: RTL and testbench
=============================

# mac_tx_arb

Packet-granular transmit arbiter between the protocol engines (ARP, IPv4) and the single MAC transmit path. It grants the MAC to one requester per frame in round-robin order and latches that requester's MAC header for the whole frame. It forwards the byte stream with one cycle of latency, enforces an inter-frame gap, and aborts stalled or oversize frames. It replaces the per-source FIFO and header-mux glue in the top level; `mac_vlg` consumes its output.

## Interface
- `N`, 2: number of requesters (index 0 = ARP, 1 = IPv4); 2..8.
- `MAX_LEN`, 1518: maximum payload bytes per frame before truncation.
- `GRANT_TIMEOUT`, 64: cycles a granted requester may wait before its first byte.
- `IFG_TICKS`, 12: idle cycles inserted after each frame; 0 is legal.

Ports:
- `clk`, input, 1: internal 125 MHz clock.
- `rst`, input, 1: reset, asynchronous and active-high.
- `req_pend`, input, N: requester i has a frame ready to send.
- `req_hdr`, input, mac_hdr_t [N-1:0]: header of each requester's pending frame.
- `req_v`, input, N: byte valid; contiguous high for the whole frame.
- `req_d`, input, [N-1:0][7:0]: byte data.
- `grant`, output, N: one-hot; requester i owns the MAC.
- `done`, output, N: one-cycle pulse when requester i's frame is finished or aborted.
- `err`, output, N: one-cycle pulse, coincident with `done`, when the frame was aborted.
- `tx_rdy`, input, 1: MAC is idle and can accept a new frame.
- `tx_hdr`, output, mac_hdr_t: latched header of the current frame.
- `tx_v`, output, 1: valid of the forwarded byte.
- `tx_d`, output, 8: forwarded byte.

## Operation
- State machine: IDLE, GRANT, STREAM, DRAIN, GAP.
- Reset values: state IDLE; round-robin pointer 0; `grant`, `done`, `err` and `tx_v` are 0; `tx_d` and `tx_hdr` are 0.
- IDLE:
  - Stay while `tx_rdy`=0 or `req_pend`=0.
  - Otherwise select the first set `req_pend` bit searching from the pointer upward, wrapping modulo N.
  - Register `sel`, latch `tx_hdr` from `req_hdr[sel]`, set `grant[sel]`, and go to GRANT.
  - Pointer becomes (sel+1) mod N.
- GRANT:
  - `req_v[sel]`=1 moves to STREAM.
  - If the wait counter reaches `GRANT_TIMEOUT` first: pulse `done[sel]` and `err[sel]`, drop `grant`, go to GAP.
- STREAM:
  - `tx_v`/`tx_d` are `req_v[sel]`/`req_d[sel]` registered.
  - Byte counter (16 bit, saturating) counts each valid byte.
  - Falling edge of `req_v[sel]`: pulse `done[sel]`, drop `grant`, go to GAP.
  - Byte counter reaching `MAX_LEN` with `req_v` still high: force `tx_v`=0, pulse `err[sel]`, go to DRAIN.
- DRAIN:
  - `tx_v` is held 0.
  - Falling edge of `req_v[sel]`: pulse `done[sel]`, drop `grant`, go to GAP.
- GAP:
  - Count `IFG_TICKS` cycles with `tx_v`=0, then go to IDLE.
  - With `IFG_TICKS`=0, pass through GAP in exactly one cycle.
- `req_v`/`req_d` of requesters that are not granted are ignored.
- `req_pend` and `req_hdr` changes are ignored after `grant` is asserted.
- `tx_hdr` is stable from grant until the next grant.
- `tx_rdy` is sampled only in IDLE. Deassertion mid-frame does not stall the stream; the MAC is responsible for buffering.
- Simultaneous requests: the pointer resolves them, so no requester is starved. Each requester gets at most one frame per N grants while others are pending.
- A `rst` assertion mid-frame returns everything to reset values immediately; the partial frame is dropped with no `done` pulse.

## Timing
- Grant latency: `grant` and `tx_hdr` are registered one cycle after the IDLE cycle that sees `tx_rdy`=1 and `req_pend`≠0.
- Data latency: `tx_v`/`tx_d` lag `req_v`/`req_d` by exactly 1 cycle.
- `done` is asserted on the cycle after the last valid byte is sampled, together with `tx_v` going 0.
- Minimum frame-to-frame spacing on `tx_v`: `IFG_TICKS`+2 cycles of 0 (GAP cycles, plus the IDLE and GRANT cycles).
- Timeout: `err` fires exactly `GRANT_TIMEOUT` cycles after `grant` rises.

## Test plan
- Single frame: `req_pend[1]`=1, `tx_rdy`=1, 60-byte burst 0x00..0x3B.
  - `grant`=2'b10 next cycle; `tx_hdr`=`req_hdr[1]`.
  - `tx_d` reproduces 0x00..0x3B one cycle late; one `done[1]` pulse; `err`=0.
- Contention: `req_pend`=2'b11 held high, each frame 10 bytes.
  - Grant order 0,1,0,1; each frame separated by ≥14 idle `tx_v` cycles.
- `tx_rdy`=0 with `req_pend`=2'b01.
  - No grant; grant follows 1 cycle after `tx_rdy` rises.
- Timeout: granted requester never raises `req_v`.
  - `done[0]`=`err[0]`=1 exactly 64 cycles after `grant[0]`; then the arbiter returns to IDLE and serves requester 1.
- Oversize: 1600-byte burst with `MAX_LEN`=1518.
  - Exactly 1518 bytes on `tx_v`.
  - `err` pulses at truncation; `done` pulses at the `req_v` fall.
- Reset mid-frame after 20 bytes.
  - All outputs 0 asynchronously; pointer 0; no `done`.
  - Next request is granted normally.

Source files
------------

// File: rtl/mac_tx_arb.sv
// ============================================================================
// Module   : mac_tx_arb
// Purpose  : Packet-granular round-robin transmit arbiter in front of the MAC.
//            Grants one requester per frame, latches its header, forwards the
//            byte stream with one cycle of latency, enforces the inter-frame
//            gap and aborts stalled (grant timeout) or oversize frames.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mac_tx_arb_pkg;
  // Ethernet MAC header carried alongside each frame
  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] ethertype;
  } mac_hdr_t;
endpackage

module mac_tx_arb
  import mac_tx_arb_pkg::*;
#(
  parameter int N             = 2,
  parameter int MAX_LEN       = 1518,
  parameter int GRANT_TIMEOUT = 64,
  parameter int IFG_TICKS     = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_pend,
  input  mac_hdr_t [N-1:0]  req_hdr,
  input  logic [N-1:0]      req_v,
  input  logic [N-1:0][7:0] req_d,
  output logic [N-1:0]      grant,
  output logic [N-1:0]      done,
  output logic [N-1:0]      err,
  input  logic              tx_rdy,
  output mac_hdr_t          tx_hdr,
  output logic              tx_v,
  output logic [7:0]        tx_d
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GRANT  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] sel;
  logic [15:0]   wait_cnt;
  logic [15:0]   gap_cnt;
  logic [15:0]   byte_cnt;

  logic [IW-1:0] pick_idx;
  logic [IW-1:0] ptr_next;
  logic [IW-1:0] cand_idx;
  logic          pick_found;
  int            cand;
  logic [N-1:0]  pick_oh;
  logic [N-1:0]  sel_oh;
  logic          sel_v;
  logic [7:0]    sel_d;
  logic          gap_last;

  // Only the granted requester's byte lane is ever looked at
  assign sel_v = req_v[sel];
  assign sel_d = req_d[sel];

  // One-hot decodes of the candidate and of the current owner
  for (genvar i = 0; i < N; i++) begin : g_onehot
    assign pick_oh[i] = (pick_idx == IW'(i));
    assign sel_oh[i]  = (sel == IW'(i));
  end

  // Round-robin search: first pending requester at or above the pointer,
  // wrapping; scanning downward lets the nearest candidate win
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      cand_idx = cand[IW-1:0];
      if (req_pend[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Pointer moves just past the requester being granted
  assign ptr_next = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + IW'(1);

  // A zero-length gap still spends exactly one cycle in GAP
  assign gap_last = (IFG_TICKS == 0) || (gap_cnt == 16'(IFG_TICKS - 1));

  // Arbitration FSM with registered grant/done/err and forwarded byte stream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ptr      <= '0;
      sel      <= '0;
      grant    <= '0;
      done     <= '0;
      err      <= '0;
      tx_v     <= 1'b0;
      tx_d     <= '0;
      tx_hdr   <= '0;
      wait_cnt <= '0;
      gap_cnt  <= '0;
      byte_cnt <= '0;
    end else begin
      done <= '0;
      err  <= '0;
      case (state)
        S_IDLE: begin
          tx_v <= 1'b0;
          if (tx_rdy && pick_found) begin
            sel      <= pick_idx;
            tx_hdr   <= req_hdr[pick_idx];
            grant    <= pick_oh;
            ptr      <= ptr_next;
            wait_cnt <= '0;
            state    <= S_GRANT;
          end
        end

        S_GRANT: begin
          if (sel_v) begin
            // First byte is forwarded on the same edge that leaves GRANT
            tx_v     <= 1'b1;
            tx_d     <= sel_d;
            byte_cnt <= 16'd1;
            state    <= S_STREAM;
          end else if (wait_cnt == 16'(GRANT_TIMEOUT - 1)) begin
            done    <= sel_oh;
            err     <= sel_oh;
            grant   <= '0;
            gap_cnt <= '0;
            state   <= S_GAP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end

        S_STREAM: begin
          if (!sel_v) begin
            // req_v was high last cycle, so low now is the falling edge
            tx_v    <= 1'b0;
            done    <= sel_oh;
            grant   <= '0;
            gap_cnt <= '0;
            state   <= S_GAP;
          end else if (byte_cnt >= 16'(MAX_LEN)) begin
            tx_v  <= 1'b0;
            err   <= sel_oh;
            state <= S_DRAIN;
          end else begin
            tx_v <= 1'b1;
            tx_d <= sel_d;
            if (byte_cnt != 16'hFFFF) begin
              byte_cnt <= byte_cnt + 16'd1;
            end
          end
        end

        S_DRAIN: begin
          tx_v <= 1'b0;
          if (!sel_v) begin
            done    <= sel_oh;
            grant   <= '0;
            gap_cnt <= '0;
            state   <= S_GAP;
          end
        end

        S_GAP: begin
          tx_v <= 1'b0;
          if (gap_last) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end

        default: begin
          state <= S_IDLE;
          grant <= '0;
          tx_v  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mac_tx_arb.sv
// ============================================================================
// Module   : tb_mac_tx_arb
// Purpose  : Self-checking bench for mac_tx_arb (N=2, MAX_LEN=1518,
//            GRANT_TIMEOUT=64, IFG_TICKS=12).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mac_tx_arb;
  import mac_tx_arb_pkg::*;

  logic             clk;
  logic             rst;
  logic [1:0]       req_pend;
  mac_hdr_t [1:0]   req_hdr;
  logic [1:0]       req_v;
  logic [1:0][7:0]  req_d;
  logic [1:0]       grant;
  logic [1:0]       done;
  logic [1:0]       err;
  logic             tx_rdy;
  mac_hdr_t         tx_hdr;
  logic             tx_v;
  logic [7:0]       tx_d;

  int checks = 0;
  int errors = 0;

  mac_tx_arb #(
    .N            (2),
    .MAX_LEN      (1518),
    .GRANT_TIMEOUT(64),
    .IFG_TICKS    (12)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req_pend(req_pend),
    .req_hdr (req_hdr),
    .req_v   (req_v),
    .req_d   (req_d),
    .grant   (grant),
    .done    (done),
    .err     (err),
    .tx_rdy  (tx_rdy),
    .tx_hdr  (tx_hdr),
    .tx_v    (tx_v),
    .tx_d    (tx_d)
  );

  // 125 MHz clock
  initial clk = 1'b0;
  always #4 clk = ~clk;

  // Hard stop in case something never terminates
  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0] pend;
    int         len;
    logic [7:0] first;
    logic [1:0] exp_grant;
  } frame_vec_t;

  frame_vec_t vecs [6];

  function automatic mac_hdr_t hdr_val(input int idx);
    mac_hdr_t h;
    h.dst       = 48'h0200_0000_0010 + 48'(idx);
    h.src       = 48'h02AA_BBCC_DD00 + 48'(idx);
    h.ethertype = (idx == 1) ? 16'h0800 : 16'h0806;
    return h;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    req_pend = 2'b00;
    req_v    = 2'b00;
    req_d    = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive len bytes on lane idx (other lane chatters junk), then drop req_v
  // and sample once more so the caller can look at done/err.
  task automatic stream(input int idx, input int len, input logic [7:0] first,
                        output int bad, output int vcnt);
    logic [7:0] b;
    bad  = 0;
    vcnt = 0;
    for (int i = 0; i < len; i++) begin
      b          = first + 8'(i);
      req_v      = 2'b11;
      req_d[idx] = b;
      req_d[1-idx] = 8'hEE;
      @(posedge clk); #1;
      if (tx_v === 1'b1) vcnt++;
      if (tx_v !== 1'b1 || tx_d !== b || done !== 2'b00 || err !== 2'b00) bad++;
    end
    req_v = 2'b00;
    req_d = '0;
    @(posedge clk); #1;
  endtask

  // Full single frame from an idle arbiter
  task automatic run_frame(input int n, input logic [1:0] pend, input int len,
                           input logic [7:0] first, input logic [1:0] exp_grant);
    int idx, bad, vcnt;
    mac_hdr_t h;
    string tag;
    tag      = $sformatf("vec%0d", n);
    idx      = exp_grant[1] ? 1 : 0;
    h        = hdr_val(idx);
    req_pend = pend;
    tx_rdy   = 1'b1;
    @(posedge clk); #1;
    check({tag, " grant"}, 128'(grant), 128'(exp_grant));
    check({tag, " hdr"}, 128'(tx_hdr), 128'(h));
    req_pend = 2'b00;
    req_hdr[0].ethertype = 16'hDEAD;
    req_hdr[1].ethertype = 16'hBEEF;
    stream(idx, len, first, bad, vcnt);
    check({tag, " bytes_bad"}, 128'(bad), 128'(0));
    check({tag, " bytes_cnt"}, 128'(vcnt), 128'(len));
    check({tag, " end_done_err_v_grant"}, 128'({done, err, tx_v, grant}),
          128'({exp_grant, 2'b00, 1'b0, 2'b00}));
    check({tag, " hdr_hold"}, 128'(tx_hdr), 128'(h));
    req_hdr[0] = hdr_val(0);
    req_hdr[1] = hdr_val(1);
  endtask

  initial begin
    int bad, vcnt, zeros, cyc, got, ng, errat, errcnt, dcnt;
    logic [1:0] exp_order [4];
    logic [7:0] b;

    // {pend, len, first byte, expected grant}; pointer evolution hand-traced
    vecs[0] = '{pend: 2'b10, len: 60,   first: 8'h00, exp_grant: 2'b10}; // ptr 0 -> 0
    vecs[1] = '{pend: 2'b01, len: 10,   first: 8'h40, exp_grant: 2'b01}; // ptr 0 -> 1
    vecs[2] = '{pend: 2'b11, len: 10,   first: 8'h80, exp_grant: 2'b10}; // ptr 1 -> 0
    vecs[3] = '{pend: 2'b11, len: 1,    first: 8'hA0, exp_grant: 2'b01}; // ptr 0 -> 1
    vecs[4] = '{pend: 2'b01, len: 5,    first: 8'hC0, exp_grant: 2'b01}; // ptr 1 -> 1
    vecs[5] = '{pend: 2'b11, len: 1518, first: 8'h10, exp_grant: 2'b10}; // ptr 1 -> 0

    rst      = 1'b1;
    req_pend = 2'b00;
    req_v    = 2'b00;
    req_d    = '0;
    tx_rdy   = 1'b0;
    req_hdr[0] = hdr_val(0);
    req_hdr[1] = hdr_val(1);
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 128'({grant, done, err, tx_v, tx_d, tx_hdr}), 128'(0));
    rst = 1'b0;
    idle_cycles(2);

    // ---------------- table-driven frames ----------------
    for (int v = 0; v < 6; v++) begin
      run_frame(v, vecs[v].pend, vecs[v].len, vecs[v].first, vecs[v].exp_grant);
      idle_cycles(16);
    end

    // ---------------- contention, pend held high ----------------
    exp_order[0] = 2'b01; exp_order[1] = 2'b10;
    exp_order[2] = 2'b01; exp_order[3] = 2'b10;
    req_pend = 2'b11;
    tx_rdy   = 1'b1;
    zeros    = 0;
    for (int f = 0; f < 4; f++) begin
      got = 0;
      for (int c = 0; c < 100 && got == 0; c++) begin
        @(posedge clk); #1;
        if (tx_v === 1'b0) zeros++;
        if (grant !== 2'b00) got = 1;
      end
      check($sformatf("cont%0d grant", f), 128'(grant), 128'(exp_order[f]));
      if (f > 0) check($sformatf("cont%0d gap", f), 128'(zeros), 128'(14));
      stream(exp_order[f][1] ? 1 : 0, 10, 8'(f * 16), bad, vcnt);
      check($sformatf("cont%0d bytes", f), 128'({bad, vcnt}), 128'({32'd0, 32'd10}));
      check($sformatf("cont%0d done", f), 128'({done, err}), 128'({exp_order[f], 2'b00}));
      zeros = (tx_v === 1'b0) ? 1 : 0;
    end
    idle_cycles(16);

    // ---------------- tx_rdy low holds off the grant ----------------
    // pointer is 0 after the 0,1,0,1 sequence
    tx_rdy   = 1'b0;
    req_pend = 2'b01;
    ng = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (grant !== 2'b00) ng++;
    end
    check("rdy_low_nogrant", 128'(ng), 128'(0));
    tx_rdy = 1'b1;
    @(posedge clk); #1;
    check("rdy_rise_grant", 128'(grant), 128'(2'b01));

    // ---------------- grant timeout, then requester 1 served ----------------
    req_pend = 2'b10;
    cyc = 0;
    got = 0;
    for (int c = 0; c < 200 && got == 0; c++) begin
      @(posedge clk); #1;
      cyc++;
      if (done !== 2'b00) got = 1;
    end
    check("timeout_cycles", 128'(cyc), 128'(64));
    check("timeout_done_err_grant", 128'({done, err, grant}), 128'({2'b01, 2'b01, 2'b00}));
    cyc = 0;
    got = 0;
    for (int c = 0; c < 60 && got == 0; c++) begin
      @(posedge clk); #1;
      cyc++;
      if (grant !== 2'b00) got = 1;
    end
    check("after_timeout_grant", 128'(grant), 128'(2'b10));
    check("after_timeout_latency", 128'(cyc), 128'(13));
    check("after_timeout_hdr", 128'(tx_hdr), 128'(hdr_val(1)));
    req_pend = 2'b00;
    stream(1, 3, 8'h55, bad, vcnt);
    check("after_timeout_frame", 128'({bad, vcnt, done, err}),
          128'({32'd0, 32'd3, 2'b10, 2'b00}));
    idle_cycles(16);

    // ---------------- oversize frame truncation ----------------
    req_pend = 2'b01;
    @(posedge clk); #1;
    check("over_grant", 128'(grant), 128'(2'b01));
    req_pend = 2'b00;
    errat = -1; errcnt = 0; dcnt = 0; vcnt = 0; bad = 0;
    for (int i = 0; i < 1600; i++) begin
      b        = 8'(i);
      req_v    = 2'b01;
      req_d[0] = b;
      @(posedge clk); #1;
      if (tx_v === 1'b1) begin
        vcnt++;
        if (tx_d !== b) bad++;
      end
      if (err !== 2'b00) begin
        errcnt++;
        errat = i;
        if (err !== 2'b01) bad++;
      end
      if (done !== 2'b00) dcnt++;
    end
    req_v = 2'b00;
    @(posedge clk); #1;
    check("over_tx_count", 128'(vcnt), 128'(1518));
    check("over_data_bad", 128'(bad), 128'(0));
    check("over_err_once_at", 128'({errcnt, errat}), 128'({32'd1, 32'd1518}));
    check("over_no_early_done", 128'(dcnt), 128'(0));
    check("over_end_done_err", 128'({done, err, grant}), 128'({2'b01, 2'b00, 2'b00}));
    idle_cycles(16);

    // ---------------- reset mid-frame ----------------
    // pointer is 1 here, so a grant of requester 0 after reset proves it cleared
    req_pend = 2'b01;
    @(posedge clk); #1;
    check("rst_pre_grant", 128'(grant), 128'(2'b01));
    req_pend = 2'b00;
    for (int i = 0; i < 20; i++) begin
      req_v    = 2'b01;
      req_d[0] = 8'(i + 100);
      @(posedge clk); #1;
    end
    #2;
    rst   = 1'b1;
    req_v = 2'b00;
    #1;
    check("rst_async_outputs", 128'({grant, done, err, tx_v, tx_d, tx_hdr}), 128'(0));
    @(posedge clk); #1;
    check("rst_no_done", 128'({done, err}), 128'(0));
    rst      = 1'b0;
    req_pend = 2'b11;
    @(posedge clk); #1;
    check("rst_post_grant", 128'(grant), 128'(2'b01));
    req_pend = 2'b00;
    stream(0, 4, 8'h30, bad, vcnt);
    check("rst_post_frame", 128'({bad, vcnt, done, err}),
          128'({32'd0, 32'd4, 2'b01, 2'b00}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
